// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a contiguous, wrapping address window on a BRAM
// read port and re-times the 1-cycle-latency read data into a valid/ready
// stream. A 4-entry FIFO absorbs the read latency so one word per cycle is
// sustained while the consumer keeps m_ready_i high.
//
// Stream handshake: a word transfers on a rising edge where m_valid_o and
// m_ready_i are both high. Once m_valid_o is high it stays high, and
// m_data_o / m_last_o stay constant, until that transfer happens.
module bram_stream_reader #(
  parameter int DataWidth = 8,
  parameter int Depth     = 784,
  parameter int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] bram_addr_o,
  input  logic [DataWidth-1:0] bram_data_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  input  logic                 assert_on_i,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [AddrWidth-1:0] c_last_addr = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth-1:0] c_depth     = AddrWidth'(Depth);

  state_e               r_state;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] r_issue_left;
  logic                 r_inflight;
  logic                 r_inflight_last;
  logic                 r_busy;
  logic                 r_done;

  logic [DataWidth-1:0] r_fifo_data [4];
  logic                 r_fifo_last [4];
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_rd_ptr;
  logic [2:0]           r_count;

  logic w_push;
  logic w_pop;
  logic w_credit_ok;
  logic w_issue;
  logic w_head_last;

  // Credit uses the registered count only: a pop in the same cycle is not
  // counted, so a read is never issued without a guaranteed free slot.
  assign w_credit_ok = ({1'b0, r_count} + {3'b000, r_inflight}) < 4'd4;
  assign w_issue     = (r_state == ST_ISSUE) && w_credit_ok;
  assign w_push      = r_inflight;
  assign w_pop       = m_valid_o && m_ready_i;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  assign m_valid_o   = (r_count != 3'd0);
  assign m_data_o    = m_valid_o ? r_fifo_data[r_rd_ptr] : '0;
  assign m_last_o    = m_valid_o & w_head_last;
  assign bram_addr_o = r_addr;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

  // Control FSM: latch the window, issue reads under credit, wait for the last word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              r_state      <= ST_ISSUE;
              r_addr       <= base_addr_i;
              r_issue_left <= length_i;
              r_busy       <= 1'b1;
            end else begin
              // Empty transfer completes immediately without ever going busy.
              r_done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_inflight      <= 1'b1;
            r_inflight_last <= (r_issue_left == AddrWidth'(1));
            r_issue_left    <= r_issue_left - AddrWidth'(1);
            r_addr          <= (r_addr == c_last_addr) ? '0 : r_addr + AddrWidth'(1);
            if (r_issue_left == AddrWidth'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage and occupancy: capture returning read data, retire on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bram_data_i;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Simulation checks on illegal requests and FIFO misuse.
  always_ff @(posedge clk_i) begin
    if (!rst_i && assert_on_i) begin
      if (r_state == ST_IDLE && start_i) begin
        a_base_range: assert (base_addr_i < c_depth);
        a_len_range:  assert (length_i <= c_depth);
      end
      a_push_full: assert (!(w_push && r_count == 3'd4));
      a_pop_empty: assert (!(w_pop && r_count == 3'd0));
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: table of directed transfers with literal
// latency expectations, hand-written reset sequences, and randomized
// transfers checked against a queue model built from address arithmetic.
module tb_bram_stream_reader;

  localparam int DEPTH = 784;
  localparam int AW    = 10;
  localparam int DW    = 8;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            ready_pct;
    int            hold_from;
    int            inject_at;
    bit            chk_addr;
    int            exp_valid_lat;
    int            exp_done_lat;
  } vec_t;

  logic          clk;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] length_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] bram_addr_o;
  logic [DW-1:0] bram_data_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_o;
  logic          assert_on_i;
  logic [1:0]    dbg_state_o;

  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  bram_stream_reader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bram_addr_o (bram_addr_o),
    .bram_data_i (bram_data_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .assert_on_i (assert_on_i),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM read port model: one cycle of read latency
  always @(posedge clk) begin
    bram_data_i <= (int'(bram_addr_o) < DEPTH) ? mem[bram_addr_o] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: the window is a modular walk over mem, last tag on the final word
  task automatic build_expected(input int base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[(base + i) % DEPTH]});
    end
  endtask

  function automatic logic pick_ready(input vec_t v, input int j);
    if (v.hold_from >= 0 && j >= v.hold_from && j < v.hold_from + 10) return 1'b0;
    if (v.ready_pct >= 100) return 1'b1;
    return ($urandom_range(0, 99) < v.ready_pct) ? 1'b1 : 1'b0;
  endfunction

  // driver + per-cycle scoreboard for one transfer; j counts cycles after the start edge
  task automatic run_vec(input vec_t v);
    int          j;
    int          first_valid;
    int          done_at;
    int          budget;
    bit          prev_stall;
    logic [DW:0] prev_word;
    logic [DW:0] got;
    logic [DW:0] exp;
    build_expected(int'(v.base), int'(v.len));
    first_valid = -1;
    done_at     = -1;
    prev_stall  = 1'b0;
    prev_word   = '0;
    budget      = 4 * int'(v.len) + 60;
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = v.base;
    length_i    = v.len;
    @(posedge clk); #1;
    start_i   = 1'b0;
    m_ready_i = pick_ready(v, 1);
    j = 0;
    while (done_at < 0 && j < budget) begin
      @(negedge clk);
      j++;
      got = {m_last_o, m_data_o};
      if (v.chk_addr && j <= int'(v.len))
        check("bram_addr", 32'(bram_addr_o), 32'((int'(v.base) + j - 1) % DEPTH));
      if (m_valid_o && first_valid < 0) first_valid = j;
      if (v.len == '0) check("zero_len_valid", 32'(m_valid_o), 0);
      if (prev_stall) begin
        check("stall_valid_held", 32'(m_valid_o), 1);
        check("stall_word_held", 32'(got), 32'(prev_word));
      end
      if (m_valid_o && m_ready_i) begin
        check("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("stream_word", 32'(got), 32'(exp));
        end
      end
      if (done_o) begin
        done_at = j;
        check("busy_at_done", 32'(busy_o), 0);
      end else begin
        check("busy", 32'(busy_o), 32'(v.len != '0));
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_word  = got;
      @(posedge clk); #1;
      if (j == v.inject_at) begin
        start_i     = 1'b1;
        base_addr_i = 10'd100;
        length_i    = 10'd5;
      end else begin
        start_i = 1'b0;
      end
      m_ready_i = pick_ready(v, j + 1);
    end
    start_i = 1'b0;
    check("done_seen", 32'(done_at >= 0), 1);
    check("first_valid_cycle", 32'(first_valid), 32'(v.exp_valid_lat));
    if (v.exp_done_lat >= 0) check("done_cycle", 32'(done_at), 32'(v.exp_done_lat));
    check("words_left", 32'(exp_q.size()), 0);
    m_ready_i = 1'b0;
    @(negedge clk);
    check("done_pulse_width", 32'(done_o), 0);
    check("idle_valid", 32'(m_valid_o), 0);
    check("idle_busy", 32'(busy_o), 0);
  endtask

  vec_t tbl [9];

  initial begin
    vec_t v;
    int   k;
    logic [DW:0] w;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    length_i    = '0;
    m_ready_i   = 1'b0;
    assert_on_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

    // base, len, ready%, hold_from, inject_at, chk_addr, valid_lat, done_lat
    tbl[0] = '{10'd0,   10'd784, 100, -1, -1, 1'b0,  3, 787};
    tbl[1] = '{10'd5,   10'd1,   100, -1, -1, 1'b1,  3,   4};
    tbl[2] = '{10'd7,   10'd0,   100, -1, -1, 1'b0, -1,   1};
    tbl[3] = '{10'd780, 10'd8,   100, -1, -1, 1'b1,  3,  11};
    tbl[4] = '{10'd10,  10'd20,   50,  6, -1, 1'b0,  3,  -1};
    tbl[5] = '{10'd40,  10'd20,  100, -1,  6, 1'b0,  3,  23};
    tbl[6] = '{10'd100, 10'd5,   100, -1, -1, 1'b1,  3,   8};
    tbl[7] = '{10'd783, 10'd1,   100, -1, -1, 1'b1,  3,   4};
    tbl[8] = '{10'd300, 10'd12,   70, 4, -1, 1'b0,  3,  -1};

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_addr", 32'(bram_addr_o), 0);
    check("rst_valid", 32'(m_valid_o), 0);
    check("rst_data", 32'(m_data_o), 0);
    check("rst_last", 32'(m_last_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int t = 0; t < 9; t++) run_vec(tbl[t]);

    // reset in the middle of a transfer after three words
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = 10'd200;
    length_i    = 10'd50;
    @(posedge clk); #1;
    start_i   = 1'b0;
    m_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      @(negedge clk);
      if (m_valid_o && m_ready_i) begin
        w = {m_last_o, m_data_o};
        check("rst_mid_word", 32'(w), 32'({1'b0, mem[200 + k]}));
        k++;
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    check("rst_mid_words_seen", 32'(k), 3);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i     = 1'b0;
    m_ready_i = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(m_valid_o), 0);
    check("rst_mid_busy", 32'(busy_o), 0);
    check("rst_mid_done", 32'(done_o), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'(done_o), 0);
    end
    v = '{10'd300, 10'd6, 100, -1, -1, 1'b1, 3, 9};
    run_vec(v);

    // randomized transfers over randomized memory contents
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
    for (int t = 0; t < 8; t++) begin
      v.base      = AW'($urandom_range(0, DEPTH - 1));
      v.len       = AW'($urandom_range(1, 40));
      case ($urandom_range(0, 2))
        0:       v.ready_pct = 100;
        1:       v.ready_pct = 50;
        default: v.ready_pct = 80;
      endcase
      v.hold_from     = (v.ready_pct < 100 && $urandom_range(0, 1) == 1) ? int'($urandom_range(3, 12)) : -1;
      v.inject_at     = -1;
      v.chk_addr      = (v.ready_pct >= 100);
      v.exp_valid_lat = 3;
      v.exp_done_lat  = (v.ready_pct >= 100) ? int'(v.len) + 3 : -1;
      run_vec(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
